// File: rtl/lfsr_index_finder.sv
// Walks the generator's x^8+x^6+x^5+x^4+1 LFSR from a seed until it reaches a target and reports the step index.
// Latency: index k found after k+1 busy cycles, worst case MAX_STEPS. Requests arriving while busy or done are dropped, not queued.
module lfsr_index_finder #(
   parameter int MAX_STEPS = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] sw_in,
   input  logic [7:0] target,
   output logic [7:0] seq_num,
   output logic       found,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT  = 8'(MAX_STEPS - 1);
   localparam logic [7:0] NOT_FOUND = 8'hFF;

   state_t     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] tgt_q, tgt_d;
   logic [7:0] count_q, count_d;
   logic [7:0] seq_num_q, seq_num_d;
   logic       found_q, found_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      tgt_d     = tgt_q;
      count_d   = count_q;
      seq_num_d = seq_num_q;
      found_d   = found_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               lfsr_d  = sw_in;
               tgt_d   = target;
               count_d = 8'h00;
               busy_d  = 1'b1;
               found_d = 1'b0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            // Match beats the zero-lockup abort so seed 0 / target 0 reports index 0.
            if (lfsr_q == tgt_q) begin
               seq_num_d = count_q;
               found_d   = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end else if (lfsr_q == 8'h00 || count_q == LAST_CNT) begin
               seq_num_d = NOT_FOUND;
               found_d   = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end else begin
               lfsr_d  = lfsr_next(lfsr_q);
               count_d = count_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         lfsr_q    <= 8'h00;
         tgt_q     <= 8'h00;
         count_q   <= 8'h00;
         seq_num_q <= 8'h00;
         found_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         tgt_q     <= tgt_d;
         count_q   <= count_d;
         seq_num_q <= seq_num_d;
         found_q   <= found_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign seq_num = seq_num_q;
   assign found   = found_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_lfsr_index_finder.sv
// Bench for lfsr_index_finder: a per-cycle request-level model plus directed literal checks and random searches.
module tb_lfsr_index_finder;
   localparam int MAX = 255;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] sw_in = 8'h00;
   logic [7:0] target = 8'h00;
   logic [7:0] seq_num;
   logic       found, busy, done;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en = 1'b0;

   lfsr_index_finder #(.MAX_STEPS(MAX)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sw_in(sw_in), .target(target),
      .seq_num(seq_num), .found(found), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Value the generator emits for a seed at a given sequence number.
   function automatic logic [7:0] gen(input logic [7:0] seed, input int n);
      logic [7:0] s = seed;
      for (int i = 0; i < n; i++) s = step(s);
      return s;
   endfunction

   // Request-level answer: reported index, found flag and how many cycles busy stays high.
   function automatic void model_search(input logic [7:0] seed, input logic [7:0] tg,
                                        output logic [7:0] idx, output logic fnd, output int dur);
      logic [7:0] s = seed;
      bit stop = 1'b0;
      idx = 8'hFF; fnd = 1'b0; dur = MAX;
      for (int i = 0; i < MAX; i++) begin
         if (!stop) begin
            if (s == tg) begin
               idx = 8'(i); fnd = 1'b1; dur = i + 1; stop = 1'b1;
            end else if (s == 8'h00) begin
               dur = i + 1; stop = 1'b1;
            end else begin
               s = step(s);
            end
         end
      end
   endfunction

   // Expected outputs cycle by cycle: idle / searching (for dur cycles) / done pulse.
   int         m_mode = 0;
   int         m_rem = 0;
   logic [7:0] m_seq = 8'h00, r_seq = 8'h00;
   logic       m_found = 1'b0, r_found = 1'b0, m_busy = 1'b0, m_done = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode <= 0; m_rem <= 0; m_seq <= 8'h00; m_found <= 1'b0;
         m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
         case (m_mode)
            0: if (start) begin
               logic [7:0] ix; logic fd; int d;
               model_search(sw_in, target, ix, fd, d);
               r_seq <= ix; r_found <= fd; m_rem <= d;
               m_busy <= 1'b1; m_found <= 1'b0; m_mode <= 1;
            end
            1: begin
               if (m_rem == 1) begin
                  m_busy <= 1'b0; m_done <= 1'b1; m_seq <= r_seq; m_found <= r_found;
                  m_mode <= 2;
               end
               m_rem <= m_rem - 1;
            end
            default: begin
               m_done <= 1'b0; m_mode <= 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", busy, m_busy);
         check("cyc_done", done, m_done);
         check("cyc_found", found, m_found);
         check("cyc_seq_num", seq_num, m_seq);
      end
   end

   // Drives one request and measures busy cycles and done pulses until completion.
   task automatic run_search(input logic [7:0] seed, input logic [7:0] tg, input bit hold,
                             input bit scramble, output int cyc, output int pulses);
      bit got = 1'b0;
      sw_in = seed; target = tg; start = 1'b1; cyc = 0; pulses = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         if (scramble) begin
            sw_in = 8'($urandom); target = 8'($urandom);
         end
         if (busy) cyc++;
         if (done) begin
            pulses++; got = 1'b1; break;
         end
      end
      start = 1'b0;
      if (!got) check("search_timeout", 0, 1);
      @(negedge clk);
      if (done) pulses++;
   endtask

   initial begin
      int cyc, pulses;
      logic [7:0] seeds [3];
      int idxs [5];
      seeds = '{8'h01, 8'hA5, 8'hFF};
      idxs = '{0, 1, 17, 128, 254};

      // Pin the model against hand-stepped values.
      check("gen_01_1", gen(8'h01, 1), 8'h02);
      check("gen_01_4", gen(8'h01, 4), 8'h11);
      check("gen_01_255", gen(8'h01, 255), 8'h01);

      #3 reset_n = 1'b0;
      #1;
      check("rst_seq", seq_num, 0); check("rst_found", found, 0);
      check("rst_busy", busy, 0);   check("rst_done", done, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", busy, 0); check("idle_seq", seq_num, 0);

      run_search(8'h01, 8'h01, 1'b0, 1'b0, cyc, pulses);
      check("hit0_seq", seq_num, 8'h00); check("hit0_found", found, 1); check("hit0_cyc", cyc, 1);
      check("hit0_pulses", pulses, 1);
      run_search(8'h01, 8'h02, 1'b0, 1'b0, cyc, pulses);
      check("hit1_seq", seq_num, 8'h01); check("hit1_cyc", cyc, 2);
      run_search(8'h01, 8'h11, 1'b0, 1'b1, cyc, pulses);
      check("hit4_seq", seq_num, 8'h04); check("hit4_cyc", cyc, 5);

      run_search(8'h01, 8'h00, 1'b0, 1'b0, cyc, pulses);
      check("nf_seq", seq_num, 8'hFF); check("nf_found", found, 0);
      check("nf_cyc", cyc, 255); check("nf_pulses", pulses, 1);

      run_search(8'h00, 8'h5A, 1'b0, 1'b0, cyc, pulses);
      check("zero_seq", seq_num, 8'hFF); check("zero_found", found, 0); check("zero_cyc", cyc, 1);
      run_search(8'h00, 8'h00, 1'b0, 1'b0, cyc, pulses);
      check("zz_seq", seq_num, 8'h00); check("zz_found", found, 1);

      foreach (seeds[s]) begin
         foreach (idxs[k]) begin
            run_search(seeds[s], gen(seeds[s], idxs[k]), 1'b1, 1'b0, cyc, pulses);
            check("rt_seq", seq_num, idxs[k]); check("rt_found", found, 1);
            check("rt_cyc", cyc, idxs[k] + 1); check("rt_pulses", pulses, 1);
            check("rt_idle_after", busy, 0);
         end
      end

      // Reset lands mid-search; outputs drop immediately with no done pulse.
      sw_in = 8'h01; target = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("mid_busy_before", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_busy", busy, 0); check("mid_done", done, 0);
      check("mid_seq", seq_num, 0); check("mid_found", found, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_search(8'h01, 8'h11, 1'b0, 1'b0, cyc, pulses);
      check("post_rst_seq", seq_num, 8'h04); check("post_rst_found", found, 1);

      for (int r = 0; r < 30; r++) begin
         logic [7:0] sd, tg;
         sd = 8'($urandom);
         case ($urandom_range(0, 3))
            0: tg = 8'($urandom);
            1: tg = 8'h00;
            default: tg = gen(sd, $urandom_range(0, 254));
         endcase
         run_search(sd, tg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc, pulses);
         check("rnd_pulses", pulses, 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/lfsr_index_finder.md
Name: lfsr_index_finder

Overview:
Inverse of the pseudo-random generator. Given the same 8-bit seed used by the generator and a target value, it steps the identical LFSR from the seed and counts steps until the state equals the target. It reports the sequence index: the seq_num that makes the generator emit that target. It sits beside the generator on the same switch/start/busy front end, so an observed number can be checked or decoded back to its position.

Parameters:
MAX_STEPS, 255, maximum number of LFSR states compared before reporting not-found. Must be ≤255 because seq_num 0xFF is reserved as the not-found code.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  level-sampled request. Accepted only in IDLE.
sw_in  input  8  LFSR seed, sampled on the accepting edge.
target  input  8  value to locate, sampled on the accepting edge.
seq_num  output  8  step index where the target was found. 0xFF when not found.
found  output  1  1 = last search matched.
busy  output  1  high while a search is in progress.
done  output  1  one-cycle pulse when a search completes.

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low (reset_n). While reset_n=0:
  - state=IDLE
  - seq_num=0x00, found=0, busy=0, done=0
  - internal lfsr=0x00, count=0x00, target register=0x00
- LFSR is identical to the generator: Fibonacci, x^8+x^6+x^5+x^4+1.
  - next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
  - Index 0 is the seed itself.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - When start=1 at edge T: lfsr<=sw_in, tgt<=target, count<=0, busy<=1, found<=0, go SEARCH.
  - seq_num and found keep their previous results until this edge.
- SEARCH, evaluated every edge in priority order:
  - (1) lfsr==tgt: seq_num<=count, found<=1, busy<=0, done<=1, go DONE.
  - (2) lfsr==0x00 (zero seed, target≠0): seq_num<=0xFF, found<=0, busy<=0, done<=1, go DONE. This is an early abort because the zero state locks up.
  - (3) count==MAX_STEPS-1: seq_num<=0xFF, found<=0, busy<=0, done<=1, go DONE.
  - (4) otherwise: lfsr<=next, count<=count+1.
- DONE: done<=0, go IDLE unconditionally. Requests are accepted again the cycle after DONE.
- Latency:
  - Match at index k: busy high k+1 cycles. done asserts after edge T+k+1.
  - Worst case not-found: MAX_STEPS cycles.
  - Zero seed: 1 cycle.
- Zero seed with target 0x00: rule (1) has priority, so found=1, seq_num=0.
- start while busy or in DONE is ignored and not queued. sw_in and target changes during a search have no effect.
- count is 8-bit and never wraps; it is bounded by rule (3).
- Reset mid-search: immediate abort to reset values, with no done pulse.
- Outputs are registered with no combinational input-to-output paths.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately (asynchronous). Release, idle 5 cycles -> outputs unchanged.
- Direct hits:
  - sw_in=0x01, target=0x01 -> busy 1 cycle, done pulse, found=1, seq_num=0x00.
  - target=0x02 -> seq_num=0x01, busy 2 cycles.
  - target=0x11 -> seq_num=0x04, busy 5 cycles.
- Not found: sw_in=0x01, target=0x00 -> busy exactly 255 cycles, then found=0, seq_num=0xFF, single done pulse.
- Zero seed:
  - sw_in=0x00, target=0x5A -> not found after 1 cycle, seq_num=0xFF.
  - sw_in=0x00, target=0x00 -> found, seq_num=0x00.
- Round trip against the generator: for seeds {0x01, 0xA5, 0xFF} and seq_num {0, 1, 17, 128, 254}, feed the generator's num as target -> seq_num equals the original index and found=1. Also hold start high across the search -> exactly one search per acceptance, and the start pulse is ignored while busy.
- Reset mid-search: sw_in=0x01, target=0x00, pull reset_n low 20 cycles into the search -> busy=0 at once, no done pulse. A fresh search afterwards gives correct results.
